// File: rtl/spi_frame_pkg.sv
// Shared constants, frame field positions and state encodings for the SPI frame engine.
package spi_frame_pkg;

  localparam int unsigned FRAME_W  = 64;
  localparam int unsigned HDR_W    = 32;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned RW_BIT   = 63;
  localparam int unsigned ADDR_MSB = 62;

  // At the header rise the newest MOSI bit is not in the shifter yet, so frame bit k sits at k-33
  localparam int unsigned HDR_ADDR_MSB = ADDR_MSB - (FRAME_W - HDR_W) - 1;

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_SHIFT   = 5'b00010,
    ST_RD_WAIT = 5'b00100,
    ST_RD_OUT  = 5'b01000,
    ST_DONE    = 5'b10000
  } state_e;

endpackage

// File: rtl/spi_frame_engine_if.sv
// Register-bus side of the SPI frame engine: write strobe, read request and read return.
interface spi_frame_engine_if;
  import spi_frame_pkg::*;

  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_valid;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    input  reg_rd_data, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
    output reg_rd_data, reg_rd_valid
  );

endinterface

// File: rtl/spi_edge_det.sv
// Rise/fall detector for the synchronised SPI clock and chip select.
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic cs_i,
  input  logic sck_i,
  output logic cs_rise_c,
  output logic cs_fall_c,
  output logic sck_rise_c,
  output logic sck_fall_c
);

  logic sck_d_q;
  logic cs_d_q;

  // CS history follows the pin through reset so a CS already low is not seen as a new fall
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_d_q <= 1'b1;
      cs_d_q  <= cs_i;
    end else begin
      sck_d_q <= sck_i;
      cs_d_q  <= cs_i;
    end
  end

  assign cs_rise_c  =  cs_i & ~cs_d_q;
  assign cs_fall_c  = ~cs_i &  cs_d_q;
  assign sck_rise_c = ~cs_i &  sck_i & ~sck_d_q;
  assign sck_fall_c = ~cs_i & ~sck_i &  sck_d_q;

endmodule

// File: rtl/spi_frame_engine.sv
// SPI slave frame engine: shifts a 64-bit frame, issues register write/read, drives MISO, flags completion.
module spi_frame_engine
  import spi_frame_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_cs_r3,
  input  logic                      spi_sck_r3,
  input  logic                      spi_mosi_r3,
  input  logic                      spi_wr_en_r,
  input  logic                      spi_rd_en_r,
  output logic                      spi_miso,
  spi_frame_engine_if.master        reg_bus,
  output logic                      rxd_flag,
  output logic                      txd_flag,
  output logic                      frame_err
);

  logic cs_rise_c, cs_fall_c, sck_rise_c, sck_fall_c;

  spi_edge_det u_edge_det (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (spi_cs_r3),
    .sck_i      (spi_sck_r3),
    .cs_rise_c  (cs_rise_c),
    .cs_fall_c  (cs_fall_c),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic               rd_miss_q, rd_miss_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               miso_q, miso_d;
  logic               rxd_q, rxd_d;
  logic               txd_q, txd_d;
  logic               err_q, err_d;
  logic               hdr_rise_c;
  logic               full_c;
  logic               unused_rw;

  assign hdr_rise_c = (state_q == ST_SHIFT) && sck_rise_c && (cnt_q == CNT_HDR_LAST);
  assign full_c     = (cnt_q == CNT_FULL);
  // The decoder owns the direction; the R/W header bit is carried but not acted on here
  assign unused_rw  = shift_q[RW_BIT];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise_c) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (cs_fall_c || pend_q) state_d = ST_SHIFT;
        ST_SHIFT:   if (hdr_rise_c && spi_rd_en_r) state_d = ST_RD_WAIT;
        ST_RD_WAIT: if (reg_bus.reg_rd_valid || sck_fall_c) state_d = ST_RD_OUT;
        ST_RD_OUT:  state_d = ST_RD_OUT;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rd_miss_d = rd_miss_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pend_d    = (state_q == ST_DONE) && cs_fall_c;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    miso_d    = 1'b0;
    rxd_d     = 1'b0;
    txd_d     = 1'b0;
    err_d     = 1'b0;

    if (state_q == ST_IDLE && state_d == ST_SHIFT) begin
      cnt_d     = '0;
      shift_d   = '0;
      tx_d      = '0;
      rd_miss_d = 1'b0;
    end

    if ((state_q inside {ST_SHIFT, ST_RD_WAIT, ST_RD_OUT}) && sck_rise_c && !full_c) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = {shift_q[FRAME_W-2:0], spi_mosi_r3};
    end

    if (hdr_rise_c) begin
      addr_d  = shift_q[HDR_ADDR_MSB -: ADDR_W];
      rd_en_d = spi_rd_en_r;
    end

    // Valid wins over a coincident fall; a fall first means the responder missed its window
    if (state_q == ST_RD_WAIT && state_d == ST_RD_OUT) begin
      if (reg_bus.reg_rd_valid) begin
        tx_d = reg_bus.reg_rd_data;
      end else begin
        tx_d      = '0;
        rd_miss_d = 1'b1;
      end
    end

    if (state_q == ST_RD_OUT && state_d == ST_RD_OUT) begin
      miso_d = miso_q;
      if (sck_fall_c) begin
        miso_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
    end

    // Completion actions land in the DONE cycle; the flag always fires for an asserted enable
    if (cs_rise_c) begin
      if (spi_wr_en_r) begin
        rxd_d = 1'b1;
        if (full_c) begin
          wr_en_d = 1'b1;
          wdata_d = shift_q[DATA_W-1:0];
        end else begin
          err_d = 1'b1;
        end
      end
      if (spi_rd_en_r) begin
        txd_d = 1'b1;
        if (!full_c || rd_miss_q) err_d = 1'b1;
      end
      if (!spi_wr_en_r && !spi_rd_en_r) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rd_miss_q <= 1'b0;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      miso_q    <= 1'b0;
      rxd_q     <= 1'b0;
      txd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_miss_q <= rd_miss_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      miso_q    <= miso_d;
      rxd_q     <= rxd_d;
      txd_q     <= txd_d;
      err_q     <= err_d;
    end
  end

  assign spi_miso            = miso_q;
  assign reg_bus.reg_wr_en   = wr_en_q;
  assign reg_bus.reg_rd_en   = rd_en_q;
  assign reg_bus.reg_addr    = addr_q;
  assign reg_bus.reg_wr_data = wdata_q;
  assign rxd_flag            = rxd_q;
  assign txd_flag            = txd_q;
  assign frame_err           = err_q;

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed bench for spi_frame_engine: completion events go through an expected-event queue.
module tb_spi_frame_engine;
  import spi_frame_pkg::*;

  localparam int unsigned HALF = 8;

  typedef struct packed {
    logic              wr;
    logic              rxd;
    logic              txd;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst, cs, sck, mosi, wr_en_r, rd_en_r;
  logic miso, rxd, txd, ferr;
  logic        resp_en;
  logic [31:0] resp_data;
  int vectors    = 0;
  int miscompares = 0;
  int rd_req_cnt = 0;
  ev_t exp_q[$];

  spi_frame_engine_if bus ();

  spi_frame_engine dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_r3   (cs),
    .spi_sck_r3  (sck),
    .spi_mosi_r3 (mosi),
    .spi_wr_en_r (wr_en_r),
    .spi_rd_en_r (rd_en_r),
    .spi_miso    (miso),
    .reg_bus     (bus),
    .rxd_flag    (rxd),
    .txd_flag    (txd),
    .frame_err   (ferr)
  );

  always #5 clk = ~clk;

  // Every cycle with a strobe or flag must match the next queued event
  always @(negedge clk) begin : mon
    ev_t obs;
    ev_t exp_ev;
    if (bus.reg_rd_en === 1'b1) rd_req_cnt++;
    if (rst === 1'b0 && (bus.reg_wr_en | rxd | txd | ferr) === 1'b1) begin
      obs.wr   = bus.reg_wr_en;
      obs.rxd  = rxd;
      obs.txd  = txd;
      obs.err  = ferr;
      obs.addr = bus.reg_addr;
      obs.data = (bus.reg_wr_en === 1'b1) ? bus.reg_wr_data : '0;
      if (exp_q.size() > 0) exp_ev = exp_q.pop_front();
      else                  exp_ev = '0;
      vectors++;
      assert (obs === exp_ev) else begin
        miscompares++;
        $error("FAIL event observed=%h expected=%h", obs, exp_ev);
      end
    end
  end

  // Register responder: valid three clocks after the read request, when enabled
  initial begin
    bus.reg_rd_valid = 1'b0;
    bus.reg_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.reg_rd_en === 1'b1 && resp_en) begin
        repeat (3) @(posedge clk);
        #1;
        bus.reg_rd_valid = 1'b1;
        bus.reg_rd_data  = resp_data;
        @(posedge clk);
        #1;
        bus.reg_rd_valid = 1'b0;
        bus.reg_rd_data  = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({miso, bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr, bus.reg_wr_data, rxd, txd, ferr});
  endfunction

  function automatic ev_t mk(input logic w, input logic r, input logic t, input logic e,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ev_t ev;
    ev.wr = w; ev.rxd = r; ev.txd = t; ev.err = e; ev.addr = a; ev.data = d;
    return ev;
  endfunction

  task automatic sck_bit(input logic b, input logic first, input logic wr, input logic rd,
                         output logic m);
    sck  = 1'b0;
    mosi = b;
    tick(HALF);
    m = miso;
    if (first) begin
      wr_en_r = wr;
      rd_en_r = rd;
    end
    sck = 1'b1;
    tick(HALF);
  endtask

  task automatic frame(input string tag, input logic [63:0] f, input int nbits,
                       input logic wr, input logic rd, input ev_t exp_ev,
                       input logic [31:0] exp_miso, input int exp_rdreq, input int gap);
    logic [31:0] mword;
    logic        m;
    int          base;
    exp_q.push_back(exp_ev);
    base  = rd_req_cnt;
    mword = '0;
    cs = 1'b0;
    tick(2);
    for (int i = 0; i < nbits; i++) begin
      sck_bit(f[63-i], i == 0, wr, rd, m);
      if (i >= 32) mword[63-i] = m;
    end
    tick(2);
    cs = 1'b1;
    tick(1);
    wr_en_r = 1'b0;
    rd_en_r = 1'b0;
    tick(gap - 1);
    chk({tag, "_miso"}, 64'(mword), 64'(exp_miso));
    chk({tag, "_rdreq"}, 64'(rd_req_cnt - base), 64'(exp_rdreq));
    chk({tag, "_events_seen"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic        m;
    logic [63:0] f;
    rst = 1'b1; cs = 1'b1; sck = 1'b1; mosi = 1'b0;
    wr_en_r = 1'b0; rd_en_r = 1'b0; resp_en = 1'b0; resp_data = '0;
    tick(4);
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    tick(4);

    frame("wr_full", 64'h0012_0000_DEAD_BEEF, 64, 1'b1, 1'b0,
          mk(1'b1, 1'b1, 1'b0, 1'b0, 15'h0012, 32'hDEAD_BEEF), 32'h0, 0, 6);

    resp_en = 1'b1; resp_data = 32'hA5A5_0F0F;
    frame("rd_full", 64'h8034_0000_0000_0000, 64, 1'b0, 1'b1,
          mk(1'b0, 1'b0, 1'b1, 1'b0, 15'h0034, 32'h0), 32'hA5A5_0F0F, 1, 6);

    resp_en = 1'b0;
    frame("wr_abort40", 64'h0055_0000_1234_5678, 40, 1'b1, 1'b0,
          mk(1'b0, 1'b1, 1'b0, 1'b1, 15'h0055, 32'h0), 32'h0, 0, 6);

    frame("rd_miss", 64'h8056_0000_0000_0000, 64, 1'b0, 1'b1,
          mk(1'b0, 1'b0, 1'b1, 1'b1, 15'h0056, 32'h0), 32'h0, 1, 6);

    // Reset in the middle of a write: outputs clear and nothing is reported
    f  = 64'h0033_0000_CAFE_F00D;
    cs = 1'b0;
    tick(2);
    for (int i = 0; i < 20; i++) sck_bit(f[63-i], i == 0, 1'b1, 1'b0, m);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_frame", outs(), 64'd0);
    cs = 1'b1;
    wr_en_r = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);

    frame("wr_after_rst", 64'h0A5C_0000_1357_9BDF, 64, 1'b1, 1'b0,
          mk(1'b1, 1'b1, 1'b0, 1'b0, 15'h0A5C, 32'h1357_9BDF), 32'h0, 0, 6);

    frame("b2b_first", 64'h7FFF_0000_FFFF_0000, 64, 1'b1, 1'b0,
          mk(1'b1, 1'b1, 1'b0, 1'b0, 15'h7FFF, 32'hFFFF_0000), 32'h0, 0, 2);
    frame("b2b_second", 64'h0001_0000_0000_0001, 64, 1'b1, 1'b0,
          mk(1'b1, 1'b1, 1'b0, 1'b0, 15'h0001, 32'h0000_0001), 32'h0, 0, 6);

    tick(10);
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    chk("idle_outputs", outs() & 64'h1_0000_0000_0007 , 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
